// File: rtl/dfe_notch_pkg.sv
// Shared constants and types for the DFE notch-filter coefficient bank.
// Coefficients are S16.14; 16'h4000 is unity.
package dfe_notch_pkg;

   localparam int NUM_COEFF = 5;

   localparam logic [7:0] CTRL_OFF     = 8'h00;
   localparam logic [7:0] STATUS_OFF   = 8'h04;
   localparam logic [7:0] COEFF_BASE   = 8'h10;
   localparam logic [7:0] STAGE_STRIDE = 8'h20;
   localparam logic [7:0] ACTIVE_BIT   = 8'h80;

   // Packed {b0,b1,b2,a1,a2}, b0 in the MSBs.
   localparam logic [79:0] RST_STAGE0 = {16'h4000, 16'h678E, 16'h4000, 16'h6502, 16'h3CE4};
   localparam logic [79:0] RST_STAGE1 = {16'h4000, 16'h4000, 16'h4000, 16'h3E6D, 16'h3CE4};
   localparam logic [79:0] RST_STAGEN = {16'h4000, 64'h0};

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } commit_state_e;

   function automatic logic [79:0] rst_coeff(input int stage);
      case (stage)
         0:       rst_coeff = RST_STAGE0;
         1:       rst_coeff = RST_STAGE1;
         default: rst_coeff = RST_STAGEN;
      endcase
   endfunction

endpackage

// File: rtl/notch_coeff_stage.sv
// One biquad's coefficient set: shadow/active register pairs and bypass bit.
// Copy takes the shadow values held before any write landing on the same edge.
module notch_coeff_stage
   import dfe_notch_pkg::*;
#(
   parameter int                          WIDTH     = 16,
   parameter logic [NUM_COEFF*WIDTH-1:0]  RST_COEFF = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [2:0]                   wr_idx,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         bypass_wr_en,
   input  logic                         bypass_wr_data,
   input  logic                         copy,
   output logic [NUM_COEFF*WIDTH-1:0]   shadow_o,
   output logic [NUM_COEFF*WIDTH-1:0]   active_o,
   output logic                         bypass_shadow_o,
   output logic                         bypass_active_o
);

   logic [WIDTH-1:0] shadow_q [NUM_COEFF];
   logic [WIDTH-1:0] shadow_d [NUM_COEFF];
   logic [WIDTH-1:0] active_q [NUM_COEFF];
   logic [WIDTH-1:0] active_d [NUM_COEFF];
   logic             bypass_shadow_q, bypass_shadow_d;
   logic             bypass_active_q, bypass_active_d;

   always_comb begin
      for (int k = 0; k < NUM_COEFF; k++) begin
         shadow_d[k] = (wr_en && (wr_idx == 3'(k))) ? wr_data : shadow_q[k];
         active_d[k] = copy ? shadow_q[k] : active_q[k];
      end
      bypass_shadow_d = bypass_wr_en ? bypass_wr_data : bypass_shadow_q;
      bypass_active_d = copy ? bypass_shadow_q : bypass_active_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_COEFF; k++) begin
            shadow_q[k] <= RST_COEFF[(NUM_COEFF-1-k)*WIDTH +: WIDTH];
            active_q[k] <= RST_COEFF[(NUM_COEFF-1-k)*WIDTH +: WIDTH];
         end
         bypass_shadow_q <= 1'b0;
         bypass_active_q <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_COEFF; k++) begin
            shadow_q[k] <= shadow_d[k];
            active_q[k] <= active_d[k];
         end
         bypass_shadow_q <= bypass_shadow_d;
         bypass_active_q <= bypass_active_d;
      end
   end

   always_comb begin
      shadow_o = '0;
      active_o = '0;
      for (int k = 0; k < NUM_COEFF; k++) begin
         shadow_o[(NUM_COEFF-1-k)*WIDTH +: WIDTH] = shadow_q[k];
         active_o[(NUM_COEFF-1-k)*WIDTH +: WIDTH] = active_q[k];
      end
   end

   assign bypass_shadow_o = bypass_shadow_q;
   assign bypass_active_o = bypass_active_q;

endmodule

// File: rtl/notch_coeff_apb.sv
// APB coefficient bank for the cascaded notch filters: shadow registers are
// written by software and copied to the active set on the sample strobe after a commit.
module notch_coeff_apb
   import dfe_notch_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NUM_STAGES = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                                  CLK,
   input  logic                                  rst_n,
   input  logic                                  PSEL,
   input  logic                                  PENABLE,
   input  logic                                  PWRITE,
   input  logic [ADDR_WIDTH-1:0]                 PADDR,
   input  logic [31:0]                           PWDATA,
   output logic [31:0]                           PRDATA,
   output logic                                  PREADY,
   output logic                                  PSLVERR,
   input  logic                                  sample_strobe,
   output logic [NUM_STAGES*NUM_COEFF*WIDTH-1:0] coeff_out,
   output logic [NUM_STAGES-1:0]                 bypass_out,
   output logic                                  commit_pending
);

   localparam int SW = NUM_COEFF * WIDTH;

   commit_state_e state_q, state_d;
   logic          done_q, done_d;

   logic [7:0]  addr_s, off_s, rel_s;
   logic [2:0]  stage_idx_s, coeff_idx_s;
   logic        acc_s, wr_s, is_act_s, ctrl_hit_s, status_hit_s, coeff_hit_s, err_s;
   logic [31:0] rdata_s;
   logic [SW-1:0]    sel_shadow_s, sel_active_s;
   logic [WIDTH-1:0] sel_word_s;
   logic [SW-1:0]    shadow_flat_s [NUM_STAGES];
   logic [NUM_STAGES-1:0] byp_shadow_s, coeff_wr_s;
   logic        ctrl_wr_s, commit_wr_s, w1c_s, copy_s;
   logic        unused_pwdata_s;

   assign addr_s          = 8'(PADDR);
   assign unused_pwdata_s = ^PWDATA[31:WIDTH];

   // Address decode, error detection and combinational read mux.
   always_comb begin
      acc_s        = PSEL & PENABLE;
      wr_s         = acc_s & PWRITE;
      is_act_s     = (addr_s & ACTIVE_BIT) != 8'h00;
      off_s        = addr_s & ~ACTIVE_BIT;
      rel_s        = off_s - COEFF_BASE;
      stage_idx_s  = 3'(rel_s / STAGE_STRIDE);
      coeff_idx_s  = 3'((rel_s % STAGE_STRIDE) >> 2);
      ctrl_hit_s   = addr_s == CTRL_OFF;
      status_hit_s = addr_s == STATUS_OFF;
      coeff_hit_s  = (addr_s[1:0] == 2'b00) && (off_s >= COEFF_BASE) &&
                     (int'(coeff_idx_s) < NUM_COEFF) && (int'(stage_idx_s) < NUM_STAGES);

      sel_shadow_s = '0;
      sel_active_s = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         sel_shadow_s = (stage_idx_s == 3'(s)) ? shadow_flat_s[s] : sel_shadow_s;
         sel_active_s = (stage_idx_s == 3'(s)) ? coeff_out[s*SW +: SW] : sel_active_s;
      end
      sel_word_s = '0;
      for (int k = 0; k < NUM_COEFF; k++) begin
         sel_word_s = (coeff_idx_s != 3'(k)) ? sel_word_s :
                      is_act_s ? sel_active_s[(NUM_COEFF-1-k)*WIDTH +: WIDTH] :
                                 sel_shadow_s[(NUM_COEFF-1-k)*WIDTH +: WIDTH];
      end

      err_s   = 1'b0;
      rdata_s = 32'h0;
      if (!acc_s) begin
         err_s   = 1'b0;
         rdata_s = 32'h0;
      end else if (ctrl_hit_s) begin
         rdata_s = 32'(byp_shadow_s) << 8;
      end else if (status_hit_s) begin
         err_s   = PWRITE & PWDATA[0];
         rdata_s = err_s ? 32'h0 : {30'h0, done_q, state_q == PENDING};
      end else if (coeff_hit_s) begin
         err_s   = PWRITE & is_act_s;
         rdata_s = err_s ? 32'h0 : 32'(sel_word_s);
      end else begin
         err_s   = 1'b1;
         rdata_s = 32'h0;
      end
   end

   // Write strobes; errored accesses never reach any register.
   always_comb begin
      ctrl_wr_s   = wr_s & ctrl_hit_s;
      commit_wr_s = ctrl_wr_s & PWDATA[0];
      w1c_s       = wr_s & status_hit_s & ~err_s & PWDATA[1];
      copy_s      = (state_q == PENDING) & sample_strobe;
      for (int s = 0; s < NUM_STAGES; s++) begin
         coeff_wr_s[s] = wr_s & coeff_hit_s & ~is_act_s & (stage_idx_s == 3'(s));
      end
   end

   // Commit FSM next state and sticky DONE; a set on the copy edge beats a clear.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = commit_wr_s ? PENDING : IDLE;
         PENDING: state_d = sample_strobe ? IDLE : PENDING;
         default: state_d = IDLE;
      endcase
      done_d = copy_s ? 1'b1 : (w1c_s ? 1'b0 : done_q);
   end

   // Commit state and DONE registers.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      notch_coeff_stage #(
         .WIDTH     (WIDTH),
         .RST_COEFF (rst_coeff(s))
      ) u_stage (
         .clk             (CLK),
         .rst_n           (rst_n),
         .wr_en           (coeff_wr_s[s]),
         .wr_idx          (coeff_idx_s),
         .wr_data         (PWDATA[WIDTH-1:0]),
         .bypass_wr_en    (ctrl_wr_s),
         .bypass_wr_data  (PWDATA[8+s]),
         .copy            (copy_s),
         .shadow_o        (shadow_flat_s[s]),
         .active_o        (coeff_out[s*SW +: SW]),
         .bypass_shadow_o (byp_shadow_s[s]),
         .bypass_active_o (bypass_out[s])
      );
   end

   assign PRDATA         = rdata_s;
   assign PSLVERR        = err_s;
   assign PREADY         = 1'b1;
   assign commit_pending = state_q == PENDING;

endmodule

// File: tb/tb_notch_coeff_apb.sv
// Directed plus randomized bench for notch_coeff_apb against a register-map model.
`timescale 1ns/1ps
module tb_notch_coeff_apb;

   localparam int NS = 2;
   localparam int NC = 5;

   logic         CLK = 1'b0;
   logic         rst_n = 1'b0;
   logic         PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, sample_strobe = 1'b0;
   logic [7:0]   PADDR = 8'h00;
   logic [31:0]  PWDATA = 32'h0;
   logic [31:0]  PRDATA;
   logic         PREADY, PSLVERR, commit_pending;
   logic [159:0] coeff_out;
   logic [1:0]   bypass_out;

   always #5 CLK = ~CLK;

   notch_coeff_apb #(.WIDTH(16), .NUM_STAGES(NS), .ADDR_WIDTH(8)) dut (
      .CLK(CLK), .rst_n(rst_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .sample_strobe(sample_strobe), .coeff_out(coeff_out), .bypass_out(bypass_out),
      .commit_pending(commit_pending));

   int total = 0;
   int passed = 0;

   // Reference model of the register map.
   logic [15:0] sh [NS][NC];
   logic [15:0] ac [NS][NC];
   logic [1:0]  sbyp, abyp;
   bit          pend, done;

   localparam logic [159:0] RST_COEFF =
      160'h4000_4000_4000_3E6D_3CE4_4000_678E_4000_6502_3CE4;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic void m_reset();
      logic [15:0] r0 [NC] = '{16'h4000, 16'h678E, 16'h4000, 16'h6502, 16'h3CE4};
      logic [15:0] r1 [NC] = '{16'h4000, 16'h4000, 16'h4000, 16'h3E6D, 16'h3CE4};
      for (int k = 0; k < NC; k++) begin
         sh[0][k] = r0[k]; ac[0][k] = r0[k];
         sh[1][k] = r1[k]; ac[1][k] = r1[k];
      end
      sbyp = 2'b00; abyp = 2'b00; pend = 1'b0; done = 1'b0;
   endfunction

   // kind: 0 CTRL, 1 STATUS, 2 coefficient, 3 unmapped
   function automatic void m_decode(input logic [7:0] a, output int kind, output int s,
                                    output int k, output bit act);
      int off;
      off = int'(a) % 128;
      act = int'(a) >= 128;
      s = (off - 16) / 32;
      k = ((off - 16) % 32) / 4;
      if (int'(a) % 4 != 0)                          kind = 3;
      else if (a == 8'h00)                           kind = 0;
      else if (a == 8'h04)                           kind = 1;
      else if (off >= 16 && s < NS && k < NC)        kind = 2;
      else                                           kind = 3;
   endfunction

   function automatic bit m_err(input logic [7:0] a, input bit wr, input logic [31:0] d);
      int kind, s, k; bit act;
      m_decode(a, kind, s, k, act);
      case (kind)
         1:       return wr && d[0];
         2:       return wr && act;
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int kind, s, k; bit act;
      m_decode(a, kind, s, k, act);
      case (kind)
         0:       return {22'h0, sbyp, 8'h00};
         1:       return {30'h0, done, pend};
         2:       return act ? {16'h0, ac[s][k]} : {16'h0, sh[s][k]};
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge with an optional write and optional strobe.
   function automatic void m_edge(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                  input bit stb);
      int kind, s, k; bit act, was_pend, copy;
      m_decode(a, kind, s, k, act);
      was_pend = pend;
      copy = pend && stb;
      if (copy) begin
         ac = sh; abyp = sbyp; pend = 1'b0;
      end
      if (wr && !m_err(a, 1'b1, d)) begin
         if (kind == 0) begin
            sbyp = d[9:8];
            if (d[0] && !was_pend) pend = 1'b1;
         end else if (kind == 1) begin
            if (d[1]) done = 1'b0;
         end else if (kind == 2) begin
            sh[s][k] = d[15:0];
         end
      end
      if (copy) done = 1'b1;
   endfunction

   function automatic logic [159:0] m_coeff();
      logic [159:0] r = '0;
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < NC; k++)
            r[(s*NC + (NC-1-k))*16 +: 16] = ac[s][k];
      return r;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_coeff"}, coeff_out, m_coeff());
      check({tag, "_bypass"}, 160'(bypass_out), 160'(abyp));
      check({tag, "_pending"}, 160'(commit_pending), 160'(pend));
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit stb,
                            input string tag);
      logic err;
      @(posedge CLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge CLK); #1;
      PENABLE = 1'b1; sample_strobe = stb;
      @(negedge CLK);
      err = PSLVERR;
      check({tag, "_slverr"}, 160'(err), 160'(m_err(a, 1'b1, d)));
      @(posedge CLK);
      m_edge(1'b1, a, d, stb);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sample_strobe = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, input string tag);
      @(posedge CLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      @(negedge CLK);
      check({tag, "_data"}, 160'(PRDATA), 160'(m_read(a)));
      check({tag, "_slverr"}, 160'(PSLVERR), 160'(m_err(a, 1'b0, 32'h0)));
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic strobe_pulse();
      @(posedge CLK); #1;
      sample_strobe = 1'b1;
      @(posedge CLK);
      m_edge(1'b0, 8'h00, 32'h0, 1'b1);
      #1;
      sample_strobe = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge CLK); #3;
      rst_n = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sample_strobe = 1'b0;
      m_reset();
      #4;
      check("in_reset_coeff", coeff_out, RST_COEFF);
      @(posedge CLK); #3;
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] pick_addr();
      case ($urandom_range(0, 7))
         0:       return 8'($urandom_range(0, 255));
         1:       return 8'h00;
         2:       return 8'h04;
         default: return 8'(16 + 32*$urandom_range(0, NS-1) + 4*$urandom_range(0, NC-1)) |
                         ($urandom_range(0, 3) == 0 ? 8'h80 : 8'h00);
      endcase
   endfunction

   initial begin
      #200us;
      $display("FAIL watchdog expired total=%0d passed=%0d", total, passed);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  a;
      logic [31:0] d;
      int          op;

      do_reset();
      check("rst_coeff", coeff_out, RST_COEFF);
      check("rst_bypass", 160'(bypass_out), 160'(2'b00));
      check("rst_pending", 160'(commit_pending), 160'(1'b0));
      check("rst_pready", 160'(PREADY), 160'(1'b1));
      check("rst_pslverr", 160'(PSLVERR), 160'(1'b0));
      check("rst_prdata", 160'(PRDATA), 160'(32'h0));
      apb_read(8'h10, "rst_rd10");
      apb_read(8'h04, "rst_rd04");

      apb_write(8'h14, 32'hFFFF1234, 1'b0, "iso_wr14");
      apb_read(8'h14, "iso_rd14");
      check("iso_rd94_model", 160'(m_read(8'h94)), 160'(32'h0000678E));
      apb_read(8'h94, "iso_rd94");
      for (int i = 0; i < 20; i++) strobe_pulse();
      check("iso_coeff_20stb", coeff_out, RST_COEFF);

      apb_write(8'h00, 32'h1, 1'b0, "cm_wr");
      repeat (5) @(posedge CLK);
      #1;
      check("cm_pending_wait", 160'(commit_pending), 160'(1'b1));
      apb_read(8'h04, "cm_status1");
      check("cm_coeff_wait", coeff_out, RST_COEFF);
      strobe_pulse();
      check("cm_b1", 160'(coeff_out[63:48]), 160'(16'h1234));
      check_outputs("cm_after");
      apb_read(8'h04, "cm_status3");
      apb_write(8'h04, 32'h2, 1'b0, "cm_w1c");
      apb_read(8'h04, "cm_status0");

      apb_write(8'h18, 32'h2222, 1'b0, "col_wr18");
      apb_write(8'h00, 32'h1, 1'b1, "col_commit_stb");
      check("col_no_copy_b2", 160'(coeff_out[47:32]), 160'(16'h4000));
      check_outputs("col_after_commit");
      apb_write(8'h30, 32'h1111, 1'b1, "col_wr30_stb");
      check("col_s1_b0", 160'(coeff_out[159:144]), 160'(16'h4000));
      check("col_s0_b2", 160'(coeff_out[47:32]), 160'(16'h2222));
      check_outputs("col_after_copy");
      apb_read(8'h30, "col_rd30");
      apb_read(8'hB0, "col_rdB0");

      apb_write(8'h90, 32'h5555, 1'b0, "err_wr90");
      apb_write(8'h08, 32'h5555, 1'b0, "err_wr08");
      apb_read(8'h50, "err_rd50");
      check_outputs("err_after");
      apb_read(8'h10, "err_rd10");

      apb_write(8'h00, 32'h301, 1'b0, "byp_wr");
      strobe_pulse();
      check("byp_out", 160'(bypass_out), 160'(2'b11));
      apb_write(8'h00, 32'h001, 1'b0, "rm_commit");
      check("rm_pending", 160'(commit_pending), 160'(1'b1));
      do_reset();
      check("rm_pending_after", 160'(commit_pending), 160'(1'b0));
      check("rm_coeff", coeff_out, RST_COEFF);
      check_outputs("rm_after");
      apb_read(8'h14, "rm_rd14");
      apb_read(8'h00, "rm_rd00");
      apb_read(8'h04, "rm_rd04");

      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 9);
         a  = pick_addr();
         d  = $urandom();
         if (op < 4)      apb_write(a, d, 1'b0, "rnd_wr");
         else if (op < 6) apb_read(a, "rnd_rd");
         else if (op < 8) strobe_pulse();
         else             apb_write(a, d, 1'b1, "rnd_wrstb");
         check_outputs("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
